a2d_rr_sched: RTL and testbench
===============================

// Module: a2d_rr_sched
// PURPOSE
//  Round-robin scheduler that owns the A2D SPI master. It sequences ADC128S conversions of
//  ld_cell_lft, ld_cell_rght, steerPot and batt. Each nxt request converts the current channel
//  and advances the pointer. Results are held in registers and feed the steering, rider-detect
//  and battery-check logic.
//  Sits between the Segway top level and the existing SPI master; the SPI master is
//  instantiated in the parent.
// PARAMETERS
//  GAP_CYC  2     idle cycles between the convert and read SPI transactions (>=1)
//  TIMEOUT  1024  max cycles to wait for done in any WAIT state
//  CH_LL    3'd0  ADC channel for left load cell
//  CH_RL    3'd4  ADC channel for right load cell
//  CH_ST    3'd5  ADC channel for steer pot
//  CH_BT    3'd6  ADC channel for battery
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  nxt          in   1   request one conversion of the current channel (pulse)
//  wrt          out  1   start pulse to SPI master (1 cycle)
//  cmd          out  16  SPI command = {2'b00, chnl[2:0], 11'h000}
//  done         in   1   SPI master transaction complete (1-cycle pulse)
//  rd_data      in   16  SPI master response word
//  lft_ld       out  12  last left load-cell sample
//  rght_ld      out  12  last right load-cell sample
//  steer_pot    out  12  last steer-pot sample
//  batt         out  12  last battery sample
//  ch_vld       out  4   one-hot update pulse {batt, steer, rght, lft}
//  sweep_done   out  1   pulse when batt is written (full 4-channel sweep complete)
//  busy         out  1   high in any state other than IDLE
//  timeout_err  out  1   pulse when a WAIT state exceeds TIMEOUT
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0 (lft), pend=0, counter=0; every output is 0, including cmd and
//  all result registers.
//  FSM states and transitions:
//   - IDLE: on (nxt | pend), go to CNV_SEND and clear pend.
//   - CNV_SEND: wrt=1 for 1 cycle; go to CNV_WAIT.
//   - CNV_WAIT: on done, go to GAP (load GAP_CYC). The response word is discarded.
//   - GAP: count down; at 0, go to RD_SEND.
//   - RD_SEND: wrt=1 for 1 cycle; go to RD_WAIT.
//   - RD_WAIT: on done, write rd_data[11:0] to the register selected by ptr, pulse
//     ch_vld[ptr], advance ptr (wraps 3 -> 0), and go to IDLE.
//  Latency:
//   - nxt in cycle N gives wrt in cycle N+1.
//   - Result register and ch_vld update in the cycle after the done of RD_WAIT.
//  cmd is registered at entry to CNV_SEND and is held stable until return to IDLE. The same
//  channel is used for both transactions.
//  done seen in IDLE, GAP or a SEND state is ignored.
//  nxt while busy:
//   - Sets pend (1-deep).
//   - Further nxt while pend=1 is dropped.
//   - nxt coincident with the RD_WAIT done sets pend; the next conversion starts 1 cycle
//     after reaching IDLE.
//  Timeout:
//   - The counter reloads to TIMEOUT on entry to each WAIT state.
//   - If it reaches 0 without done: pulse timeout_err, go to IDLE, leave ptr unchanged,
//     leave result registers unchanged.
//  sweep_done pulses together with ch_vld[3].
//  rst mid-transaction aborts immediately: wrt=0 and state=IDLE on the next edge; pend is
//  cleared.
// STRUCTURE
//  segway_pkg holds:
//   - a2d_state_t enum {IDLE, CNV_SEND, CNV_WAIT, GAP, RD_SEND, RD_WAIT}
//   - A2D_CMD_HDR = 2'b00
//   - the channel-index localparams
//  One shared down-counter serves both GAP and TIMEOUT, kept inline; there is no sub-module.
// TESTING
//  Bench uses a behavioural SPI responder that returns done 32 cycles after wrt. Read data is
//  {4'h0, chan*12'h111}.
//  1) Reset, then 4 nxt pulses spaced 200 cycles apart:
//     - lft_ld=000, rght_ld=444, steer_pot=555, batt=666;
//     - ch_vld pulses in order lft, rght, steer, batt;
//     - sweep_done fires once.
//  2) Check cmd values for a sweep: 0x0000, 0x2000, 0x2800, 0x3000. Each value appears on
//     2 wrt pulses, with exactly GAP_CYC idle cycles between done and the second wrt.
//  3) Three nxt pulses during one busy window: exactly 2 conversions total (1 pended),
//     back-to-back with 1 IDLE cycle.
//  4) Responder withholds done in RD_WAIT:
//     - timeout_err pulses TIMEOUT cycles after entry;
//     - ptr is unchanged, so the next nxt re-converts the same channel;
//     - outputs hold their old values.
//  5) Assert rst in GAP and again in CNV_WAIT:
//     - next cycle: wrt=0, busy=0, all outputs 0;
//     - a late done is ignored.
//  6) Fifth nxt after a full sweep: ptr has wrapped to lft, and cmd=0x0000.

Source files
------------

// File: rtl/segway_pkg.sv
// ----------------------------------------------------------------------------
// segway_pkg
//   Shared types and constants for the Segway A2D front end.
//   - a2d_state_t : states of the round-robin A2D conversion scheduler
//   - A2D_CMD_HDR : two header bits that lead every ADC128S command word
//   - A2D_CH_*    : ADC128S channel numbers wired to each sensor
//   - A2D_NUM_CH  : number of sensors visited in one round-robin sweep
// ----------------------------------------------------------------------------
package segway_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNV_SEND,
    CNV_WAIT,
    GAP,
    RD_SEND,
    RD_WAIT
  } a2d_state_t;

  localparam logic [1:0] A2D_CMD_HDR = 2'b00;

  localparam logic [2:0] A2D_CH_LL = 3'd0;
  localparam logic [2:0] A2D_CH_RL = 3'd4;
  localparam logic [2:0] A2D_CH_ST = 3'd5;
  localparam logic [2:0] A2D_CH_BT = 3'd6;

  localparam int A2D_NUM_CH = 4;

endpackage

// File: rtl/a2d_rr_sched.sv
// ----------------------------------------------------------------------------
// a2d_rr_sched
//   Round-robin scheduler in front of the A2D SPI master. Each nxt request
//   converts the current sensor channel (left load cell, right load cell,
//   steer pot, battery) and then moves on to the next one. The ADC128S returns
//   the sample of the channel addressed in the previous frame, so every
//   conversion is two SPI transactions carrying the same command: a convert
//   frame whose response is thrown away, a short idle gap, and a read frame
//   whose low 12 bits are the sample.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   nxt          request one conversion of the current channel (pulse)
//   wrt, cmd     start pulse and 16-bit command word for the SPI master
//   done,rd_data SPI master completion pulse and response word
//   lft_ld, rght_ld, steer_pot, batt
//                last 12-bit sample of each sensor
//   ch_vld       one-hot update pulse {batt, steer, rght, lft}
//   sweep_done   pulse when the battery sample (end of a sweep) is written
//   busy         high whenever a conversion is in progress
//   timeout_err  pulse when the SPI master failed to answer in time
// ----------------------------------------------------------------------------
module a2d_rr_sched
  import segway_pkg::*;
#(
  parameter int         GAP_CYC = 2,
  parameter int         TIMEOUT = 1024,
  parameter logic [2:0] CH_LL   = A2D_CH_LL,
  parameter logic [2:0] CH_RL   = A2D_CH_RL,
  parameter logic [2:0] CH_ST   = A2D_CH_ST,
  parameter logic [2:0] CH_BT   = A2D_CH_BT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic [3:0]  ch_vld,
  output logic        sweep_done,
  output logic        busy,
  output logic        timeout_err
);

  // One down-counter is shared by the inter-frame gap and the done timeout,
  // so it is sized for the larger of the two (GAP_CYC never exceeds TIMEOUT).
  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_GAP = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  a2d_state_t       state;
  logic [1:0]       ptr;
  logic             pend;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cur_chnl;
  logic             unused_rd_hi;

  // The ADC128S only drives 12 data bits; the top nibble of the response
  // carries nothing useful.
  assign unused_rd_hi = ^rd_data[15:12];

  // Translate the round-robin pointer into the physical ADC channel of the
  // sensor it addresses.
  always_comb begin
    cur_chnl = CH_LL;
    case (ptr)
      2'd0: cur_chnl = CH_LL;
      2'd1: cur_chnl = CH_RL;
      2'd2: cur_chnl = CH_ST;
      2'd3: cur_chnl = CH_BT;
      default: cur_chnl = CH_LL;
    endcase
  end

  // Scheduler FSM. All outputs are registered here. The counter is loaded
  // with the number of cycles a state may last and the state is left on the
  // edge where it would reach zero, so GAP lasts exactly GAP_CYC cycles and a
  // WAIT state accepts done for exactly TIMEOUT cycles. A request arriving
  // while a conversion runs is remembered in pend (one deep) and launched
  // straight from IDLE once the current conversion finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      pend        <= 1'b0;
      cnt         <= '0;
      wrt         <= 1'b0;
      cmd         <= 16'h0000;
      lft_ld      <= 12'h000;
      rght_ld     <= 12'h000;
      steer_pot   <= 12'h000;
      batt        <= 12'h000;
      ch_vld      <= 4'b0000;
      sweep_done  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wrt         <= 1'b0;
      ch_vld      <= 4'b0000;
      sweep_done  <= 1'b0;
      timeout_err <= 1'b0;

      if ((state != IDLE) && nxt) begin
        pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (nxt || pend) begin
            state <= CNV_SEND;
            pend  <= 1'b0;
            wrt   <= 1'b1;
            busy  <= 1'b1;
            cmd   <= {A2D_CMD_HDR, cur_chnl, 11'h000};
          end
        end

        CNV_SEND: begin
          state <= CNV_WAIT;
          cnt   <= CNT_TMO;
        end

        CNV_WAIT: begin
          if (done) begin
            state <= GAP;
            cnt   <= CNT_GAP;
          end else if (cnt == CNT_ONE) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        GAP: begin
          if (cnt == CNT_ONE) begin
            state <= RD_SEND;
            cnt   <= '0;
            wrt   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        RD_SEND: begin
          state <= RD_WAIT;
          cnt   <= CNT_TMO;
        end

        RD_WAIT: begin
          if (done) begin
            case (ptr)
              2'd0: lft_ld    <= rd_data[11:0];
              2'd1: rght_ld   <= rd_data[11:0];
              2'd2: steer_pot <= rd_data[11:0];
              2'd3: batt      <= rd_data[11:0];
              default: lft_ld <= rd_data[11:0];
            endcase
            ch_vld     <= 4'b0001 << ptr;
            sweep_done <= (ptr == 2'd3);
            ptr        <= ptr + 2'd1;
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
          end else if (cnt == CNT_ONE) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_rr_sched.sv
// ----------------------------------------------------------------------------
// tb_a2d_rr_sched
//   Self-checking bench for a2d_rr_sched. A behavioural SPI responder answers
//   every wrt with a done pulse a fixed number of cycles later. A negedge
//   monitor logs every output event with its cycle number, and the main
//   sequence compares those logs against expectations worked out from
//   channel tables, a per-sensor result array and latency arithmetic.
// ----------------------------------------------------------------------------
module tb_a2d_rr_sched;

  localparam int GAP_CYC  = 2;
  localparam int TIMEOUT  = 1024;
  localparam int RESP_LAT = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        nxt;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic [3:0]  ch_vld;
  logic        sweep_done;
  logic        busy;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int          nxt_q[$];
  int          wrt_cyc[$];
  logic [15:0] wrt_cmd[$];
  int          done_cyc[$];
  int          vld_cyc[$];
  logic [3:0]  vld_val[$];
  int          sweep_cyc[$];
  int          tmo_cyc[$];

  bit          hold_done = 1'b0;
  bit          rand_data = 1'b0;
  logic [15:0] last_rd   = 16'h0000;
  int          resp_cnt  = 0;
  logic [2:0]  resp_ch   = 3'd0;

  // Reference model: sensor order as ADC channel numbers, the last sample
  // of each sensor, and which sensor the next request converts.
  int          chan_tab[4] = '{0, 4, 5, 6};
  logic [11:0] m_res[4]    = '{12'h000, 12'h000, 12'h000, 12'h000};
  int          m_ptr       = 0;

  a2d_rr_sched #(
    .GAP_CYC (GAP_CYC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .nxt         (nxt),
    .wrt         (wrt),
    .cmd         (cmd),
    .done        (done),
    .rd_data     (rd_data),
    .lft_ld      (lft_ld),
    .rght_ld     (rght_ld),
    .steer_pot   (steer_pot),
    .batt        (batt),
    .ch_vld      (ch_vld),
    .sweep_done  (sweep_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // 10-time-unit clock and a free-running cycle number used to timestamp
  // every logged event.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: outputs are registered, so the negedge sees settled
  // values for the current cycle.
  always @(negedge clk) begin
    if (wrt) begin
      wrt_cyc.push_back(cyc);
      wrt_cmd.push_back(cmd);
    end
    if (done) done_cyc.push_back(cyc);
    if (ch_vld != 4'b0000) begin
      vld_cyc.push_back(cyc);
      vld_val.push_back(ch_vld);
    end
    if (sweep_done) tmo_dummy_guard();
    if (timeout_err) tmo_cyc.push_back(cyc);
  end

  function automatic void tmo_dummy_guard();
    sweep_cyc.push_back(cyc);
  endfunction

  // Behavioural SPI master: a wrt seen in cycle W produces a one-cycle done
  // in cycle W+RESP_LAT. The response carries channel*0x111 (or a random
  // sample) with a junk top nibble. hold_done swallows responses.
  initial begin
    done    = 1'b0;
    rd_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      done = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0 && !hold_done) begin
          if (rand_data) rd_data = {4'($urandom), 12'($urandom)};
          else           rd_data = {4'($urandom), 12'(int'(resp_ch) * 'h111)};
          last_rd = rd_data;
          done    = 1'b1;
        end
      end
      if (wrt) begin
        resp_cnt = RESP_LAT;
        resp_ch  = cmd[13:11];
      end
    end
  end

  // Hard stop in case the DUT wedges somewhere a bounded wait cannot catch.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed no end of test, expected end before 40000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Wait gap cycles, then raise nxt for exactly one cycle.
  task automatic applyStimulus(input int gap);
    repeat (gap) tick();
    nxt = 1'b1;
    nxt_q.push_back(cyc);
    tick();
    nxt = 1'b0;
  endtask

  // Wait until busy has stayed low for several cycles, bounded.
  task automatic waitQuiet(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      tick();
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    checkOutput("quiet_wait", 32'(quiet >= 4), 32'd1);
  endtask

  task automatic clearLogs();
    nxt_q.delete();
    wrt_cyc.delete();
    wrt_cmd.delete();
    done_cyc.delete();
    vld_cyc.delete();
    vld_val.delete();
    sweep_cyc.delete();
    tmo_cyc.delete();
  endtask

  function automatic logic [15:0] expCmd(input int idx);
    return 16'(chan_tab[idx] * 2048);
  endfunction

  task automatic modelConvert(input logic [11:0] d);
    m_res[m_ptr] = d;
    m_ptr = (m_ptr + 1) % 4;
  endtask

  task automatic convSpecData();
    modelConvert(12'(chan_tab[m_ptr] * 'h111));
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) m_res[i] = 12'h000;
    m_ptr = 0;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_lft"},   32'(lft_ld),    32'(m_res[0]));
    checkOutput({tag, "_rght"},  32'(rght_ld),   32'(m_res[1]));
    checkOutput({tag, "_steer"}, 32'(steer_pot), 32'(m_res[2]));
    checkOutput({tag, "_batt"},  32'(batt),      32'(m_res[3]));
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_wrt"},   32'(wrt),         32'd0);
    checkOutput({tag, "_busy"},  32'(busy),        32'd0);
    checkOutput({tag, "_cmd"},   32'(cmd),         32'd0);
    checkOutput({tag, "_vld"},   32'(ch_vld),      32'd0);
    checkOutput({tag, "_sweep"}, 32'(sweep_done),  32'd0);
    checkOutput({tag, "_tmo"},   32'(timeout_err), 32'd0);
    checkRegs(tag);
  endtask

  initial begin
    int n;
    int p;
    int d2;

    rst = 1'b1;
    nxt = 1'b0;
    repeat (3) tick();
    checkZero("rst");
    rst = 1'b0;
    tick();

    // Full sweep with requests 200 cycles apart.
    $display("[TB] full sweep");
    clearLogs();
    applyStimulus(5);
    for (int k = 1; k < 4; k++) applyStimulus(199);
    waitQuiet(400);
    checkOutput("t1_nwrt",   32'(wrt_cyc.size()),   32'd8);
    checkOutput("t1_nvld",   32'(vld_cyc.size()),   32'd4);
    checkOutput("t1_nsweep", 32'(sweep_cyc.size()), 32'd1);
    if (wrt_cyc.size() == 8 && done_cyc.size() == 8 && vld_cyc.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput("t1_cmd_cnv", 32'(wrt_cmd[2*k]),     32'(expCmd(k)));
        checkOutput("t1_cmd_rd",  32'(wrt_cmd[2*k+1]),   32'(expCmd(k)));
        checkOutput("t1_lat_wrt", 32'(wrt_cyc[2*k]),     32'(nxt_q[k] + 1));
        checkOutput("t1_gap",     32'(wrt_cyc[2*k+1] - done_cyc[2*k] - 1), 32'(GAP_CYC));
        checkOutput("t1_vld_val", 32'(vld_val[k]),       32'(1 << k));
        checkOutput("t1_vld_cyc", 32'(vld_cyc[k]),       32'(done_cyc[2*k+1] + 1));
      end
      if (sweep_cyc.size() == 1)
        checkOutput("t1_sweep_cyc", 32'(sweep_cyc[0]), 32'(vld_cyc[3]));
    end
    for (int k = 0; k < 4; k++) convSpecData();
    checkRegs("t1");

    // Fifth request after a sweep wraps back to the left load cell.
    clearLogs();
    applyStimulus(20);
    waitQuiet(200);
    checkOutput("t6_nwrt", 32'(wrt_cyc.size()), 32'd2);
    if (wrt_cmd.size() == 2) begin
      checkOutput("t6_cmd0", 32'(wrt_cmd[0]), 32'h0000);
      checkOutput("t6_cmd1", 32'(wrt_cmd[1]), 32'h0000);
    end
    convSpecData();
    checkRegs("t6");

    // Three requests in one busy window: one pended, one dropped.
    $display("[TB] pending requests");
    clearLogs();
    p = m_ptr;
    applyStimulus(10);
    applyStimulus(9);
    applyStimulus(9);
    waitQuiet(400);
    checkOutput("t3_nwrt", 32'(wrt_cyc.size()), 32'd4);
    checkOutput("t3_nvld", 32'(vld_cyc.size()), 32'd2);
    if (wrt_cyc.size() == 4 && vld_cyc.size() == 2) begin
      checkOutput("t3_b2b",  32'(wrt_cyc[2]), 32'(vld_cyc[0] + 1));
      checkOutput("t3_cmdA", 32'(wrt_cmd[0]), 32'(expCmd(p)));
      checkOutput("t3_cmdB", 32'(wrt_cmd[2]), 32'(expCmd((p + 1) % 4)));
    end
    convSpecData();
    convSpecData();
    checkRegs("t3");

    // Request coincident with the read-frame done is pended.
    clearLogs();
    applyStimulus(10);
    d2 = nxt_q[0] + 1 + RESP_LAT + GAP_CYC + 1 + RESP_LAT;
    applyStimulus(d2 - cyc);
    waitQuiet(400);
    checkOutput("t3b_nwrt", 32'(wrt_cyc.size()), 32'd4);
    checkOutput("t3b_nvld", 32'(vld_cyc.size()), 32'd2);
    if (wrt_cyc.size() == 4 && vld_cyc.size() == 2 && done_cyc.size() >= 2) begin
      checkOutput("t3b_done_cyc", 32'(done_cyc[1]), 32'(d2));
      checkOutput("t3b_b2b",      32'(wrt_cyc[2]),  32'(vld_cyc[0] + 1));
    end
    convSpecData();
    convSpecData();
    checkRegs("t3b");

    // Read frame never answered: timeout, pointer and results untouched.
    $display("[TB] timeout");
    clearLogs();
    p = m_ptr;
    applyStimulus(10);
    n = 0;
    while (done_cyc.size() == 0 && n < 100) begin tick(); n++; end
    hold_done = 1'b1;
    n = 0;
    while (tmo_cyc.size() == 0 && n < TIMEOUT + 200) begin tick(); n++; end
    checkOutput("t4_ntmo", 32'(tmo_cyc.size()), 32'd1);
    if (tmo_cyc.size() == 1 && wrt_cyc.size() == 2)
      checkOutput("t4_tmo_cyc", 32'(tmo_cyc[0]), 32'(wrt_cyc[1] + 1 + TIMEOUT));
    checkOutput("t4_nvld", 32'(vld_cyc.size()), 32'd0);
    checkRegs("t4_hold");
    waitQuiet(50);
    hold_done = 1'b0;
    clearLogs();
    applyStimulus(10);
    waitQuiet(200);
    checkOutput("t4_retry_nwrt", 32'(wrt_cmd.size()), 32'd2);
    if (wrt_cmd.size() == 2) checkOutput("t4_retry_cmd", 32'(wrt_cmd[0]), 32'(expCmd(p)));
    convSpecData();
    checkRegs("t4_retry");

    // Random spacing and random samples.
    $display("[TB] random conversions");
    rand_data = 1'b1;
    for (int i = 0; i < 7; i++) begin
      clearLogs();
      p = m_ptr;
      applyStimulus(int'($urandom_range(5, 150)));
      waitQuiet(200);
      if (wrt_cmd.size() == 2) checkOutput("rnd_cmd", 32'(wrt_cmd[1]), 32'(expCmd(p)));
      else checkOutput("rnd_nwrt", 32'(wrt_cmd.size()), 32'd2);
      modelConvert(last_rd[11:0]);
      checkRegs("rnd");
    end
    rand_data = 1'b0;

    // Reset during GAP.
    $display("[TB] reset mid-transaction");
    clearLogs();
    applyStimulus(10);
    n = 0;
    while (done_cyc.size() == 0 && n < 100) begin tick(); n++; end
    tick();
    rst = 1'b1;
    tick();
    modelReset();
    checkZero("t5_gap");
    rst = 1'b0;
    waitQuiet(100);
    checkOutput("t5_gap_nwrt", 32'(wrt_cyc.size()), 32'd1);

    // Reset during CNV_WAIT; the late done must be ignored.
    clearLogs();
    applyStimulus(10);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checkZero("t5_cnv");
    rst = 1'b0;
    repeat (40) tick();
    checkOutput("t5_late_done", 32'(done_cyc.size()), 32'd1);
    checkOutput("t5_cnv_nwrt",  32'(wrt_cyc.size()),  32'd1);
    checkOutput("t5_cnv_nvld",  32'(vld_cyc.size()),  32'd0);
    checkOutput("t5_cnv_busy",  32'(busy),            32'd0);
    checkRegs("t5_cnv");

    // After reset the pointer is back on the left load cell.
    clearLogs();
    applyStimulus(10);
    waitQuiet(200);
    if (wrt_cmd.size() == 2) checkOutput("t5_post_cmd", 32'(wrt_cmd[0]), 32'h0000);
    else checkOutput("t5_post_nwrt", 32'(wrt_cmd.size()), 32'd2);
    checkOutput("t5_post_nvld", 32'(vld_val.size()), 32'd1);
    if (vld_val.size() == 1) checkOutput("t5_post_vld", 32'(vld_val[0]), 32'd1);
    convSpecData();
    checkRegs("t5_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
